// File: rtl/hub_linear_fold_seq.sv
// Folded fully-connected layer: accumulates FOLD slices per vector, then shift/ReLU/saturate.
// Optional HUB_BIAS_EN adds per-channel bias port iBias, folded into the first slice.
module hub_linear_fold_seq #(
  parameter int IDIM = 128,
  parameter int SDIM = 32,
  parameter int FOLD = IDIM / SDIM,
  parameter int ODIM = 16,
  parameter int IWID = 8,
  parameter int AWID = 2*IWID + $clog2(IDIM),
  parameter int OWID = IWID,
  parameter int SHFT = IWID - 1,
  parameter int RELU = 1,
  parameter int PWID = ($clog2(FOLD) < 1) ? 1 : $clog2(FOLD)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          clear,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [SDIM-1:0][IWID-1:0]      iFmap,
  input  logic [ODIM*SDIM-1:0][IWID-1:0] iWeig,
  output logic [PWID-1:0]               part,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [ODIM-1:0][OWID-1:0]      oFmap,
  output logic                          ovf
`ifdef HUB_BIAS_EN
  ,
  input  logic [ODIM-1:0][AWID-1:0]      iBias
`endif
);

  localparam int PW2 = 2 * IWID;
  localparam logic [PWID-1:0]        PLAST = PWID'(FOLD - 1);
  localparam logic signed [AWID-1:0] OMAX  = AWID'((2 ** (OWID - 1)) - 1);
  localparam logic signed [AWID-1:0] OMIN  = ~OMAX;

  typedef enum logic {ACC, OUT} state_t;
  state_t state;

  logic signed [AWID-1:0] psum    [ODIM];
  logic signed [AWID-1:0] acc     [ODIM];
  logic signed [AWID-1:0] acc_nxt [ODIM];
  logic signed [AWID-1:0] base;
  logic signed [AWID-1:0] shr;
  logic signed [PW2-1:0]  fm_x, wt_x;
  logic [ODIM-1:0][OWID-1:0] res;
  logic                   sat;

  always_comb begin
    fm_x = '0;
    wt_x = '0;
    for (int unsigned o = 0; o < ODIM; o++) begin
      psum[o] = '0;
      for (int unsigned s = 0; s < SDIM; s++) begin
        fm_x = PW2'($signed(iFmap[s]));
        wt_x = PW2'($signed(iWeig[o*SDIM+s]));
        psum[o] = psum[o] + AWID'(fm_x * wt_x);
      end
    end
  end

  // First slice of a vector seeds the accumulator instead of adding to it.
  always_comb begin
    base = '0;
    for (int unsigned o = 0; o < ODIM; o++) begin
`ifdef HUB_BIAS_EN
      base = $signed(iBias[o]);
`else
      base = '0;
`endif
      acc_nxt[o] = (part == '0) ? base + psum[o] : acc[o] + psum[o];
    end
  end

  always_comb begin
    sat = 1'b0;
    res = '0;
    shr = '0;
    for (int unsigned o = 0; o < ODIM; o++) begin
      shr = acc_nxt[o] >>> SHFT;
      if (RELU != 0 && shr < 0) begin
        res[o] = '0;
      end else if (shr > OMAX) begin
        res[o] = OMAX[OWID-1:0];
        sat    = 1'b1;
      end else if (shr < OMIN) begin
        res[o] = OMIN[OWID-1:0];
        sat    = 1'b1;
      end else begin
        res[o] = shr[OWID-1:0];
      end
    end
  end

  always_comb in_ready = (state == ACC);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ACC;
      part      <= '0;
      acc       <= '{default: '0};
      out_valid <= 1'b0;
      oFmap     <= '0;
      ovf       <= 1'b0;
    end else if (clear) begin
      // Flush drops any slice presented this cycle; oFmap and ovf are kept.
      state     <= ACC;
      part      <= '0;
      acc       <= '{default: '0};
      out_valid <= 1'b0;
    end else begin
      case (state)
        ACC: begin
          if (in_valid) begin
            acc <= acc_nxt;
            if (part == PLAST) begin
              part      <= '0;
              state     <= OUT;
              out_valid <= 1'b1;
              oFmap     <= res;
              if (sat) ovf <= 1'b1;
            end else begin
              part <= part + PWID'(1);
            end
          end
        end
        OUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= ACC;
          end
        end
        default: state <= ACC;
      endcase
    end
  end

endmodule

// File: tb/tb_hub_linear_fold_seq.sv
// Scoreboard bench for hub_linear_fold_seq: RELU=1 and RELU=0 instances share stimulus.
module tb_hub_linear_fold_seq;
  localparam int SDIM = 2;
  localparam int ODIM = 2;
  localparam int IWID = 4;
  localparam int OWID = 4;
  localparam int SHFT = 0;

  logic clk = 1'b0, rst = 1'b1, clear = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic [SDIM-1:0][IWID-1:0]      iFmap = '0;
  logic [ODIM*SDIM-1:0][IWID-1:0] iWeig;
  logic in_ready, out_valid, ovf, in_ready_n, out_valid_n, ovf_n;
  logic [0:0] part, part_n;
  logic [ODIM-1:0][OWID-1:0] oFmap, oFmap_n;

  hub_linear_fold_seq #(.IDIM(4), .SDIM(SDIM), .FOLD(2), .ODIM(ODIM), .IWID(IWID),
                        .OWID(OWID), .SHFT(SHFT), .RELU(1)) u_dut (
    .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid), .in_ready(in_ready),
    .iFmap(iFmap), .iWeig(iWeig), .part(part), .out_valid(out_valid),
    .out_ready(out_ready), .oFmap(oFmap), .ovf(ovf));

  hub_linear_fold_seq #(.IDIM(4), .SDIM(SDIM), .FOLD(2), .ODIM(ODIM), .IWID(IWID),
                        .OWID(OWID), .SHFT(SHFT), .RELU(0)) u_dut_n (
    .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid), .in_ready(in_ready_n),
    .iFmap(iFmap), .iWeig(iWeig), .part(part_n), .out_valid(out_valid_n),
    .out_ready(out_ready), .oFmap(oFmap_n), .ovf(ovf_n));

  always #5 clk = ~clk;

  typedef struct {
    logic [ODIM-1:0][OWID-1:0] f1;
    logic                      ov1;
    logic [ODIM-1:0][OWID-1:0] f0;
    logic                      ov0;
  } exp_t;

  exp_t sb[$];
  int   errors = 0, checks = 0;
  int   xv[4];
  int   wm[2][4];
  int   rdy_mode = 0;
  bit   ovf_m1 = 0, ovf_m0 = 0;

  // The bench acts as the weight buffer addressed by the DUT's fold index.
  always_comb begin
    for (int o = 0; o < ODIM; o++)
      for (int s = 0; s < SDIM; s++)
        iWeig[o*SDIM+s] = 4'(wm[o][int'(part)*SDIM+s]);
  end

  always @(posedge clk) begin
    #2;
    case (rdy_mode)
      0:       out_ready = 1'b1;
      1:       out_ready = 1'($urandom_range(0, 1));
      default: out_ready = 1'b0;
    endcase
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int clampv(input int v, input bit relu, output bit sat);
    sat = 0;
    if (relu && v < 0) return 0;
    if (v > 7) begin sat = 1; return 7; end
    if (v < -8) begin sat = 1; return -8; end
    return v;
  endfunction

  task automatic push_expect();
    exp_t e;
    int   dot, r;
    bit   s1, s0;
    for (int o = 0; o < ODIM; o++) begin
      dot = 0;
      for (int i = 0; i < 4; i++) dot += xv[i] * wm[o][i];
      r = dot >>> SHFT;
      e.f1[o] = 4'(clampv(r, 1'b1, s1));
      e.f0[o] = 4'(clampv(r, 1'b0, s0));
      if (s1) ovf_m1 = 1;
      if (s0) ovf_m0 = 1;
    end
    e.ov1 = ovf_m1;
    e.ov0 = ovf_m0;
    sb.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_slice(input int k);
    bit ok = 0;
    in_valid = 1'b1;
    iFmap[0] = 4'(xv[k*2]);
    iFmap[1] = 4'(xv[k*2+1]);
    for (int n = 0; n < 200 && !ok; n++) begin
      ok = in_ready;
      if (ok) begin
        chk("part", {31'd0, part}, k);
        chk("part_norelu", {31'd0, part_n}, k);
      end
      tick();
    end
    in_valid = 1'b0;
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL slice_timeout: in_ready stayed 0, required 1");
    end
  endtask

  task automatic send_vector();
    send_slice(0);
    send_slice(1);
    chk("latency_valid", out_valid, 1);
    push_expect();
  endtask

  task automatic load(input int x0, x1, x2, x3, input int wa, wb);
    xv = '{x0, x1, x2, x3};
    for (int i = 0; i < 4; i++) begin
      wm[0][i] = wa;
      wm[1][i] = wb;
    end
  endtask

  // Accept a junk slice 0, then flush it with clear (slice on the bus is dropped too).
  task automatic junk_then_clear();
    int sv[4];
    sv = xv;
    for (int i = 0; i < 4; i++) xv[i] = int'($urandom_range(0, 15)) - 8;
    xv[0] = 7;
    xv[1] = 7;
    send_slice(0);
    clear    = 1'b1;
    in_valid = 1'b1;
    iFmap    = 8'($urandom);
    tick();
    clear    = 1'b0;
    in_valid = 1'b0;
    xv = sv;
  endtask

  logic [ODIM-1:0][OWID-1:0] held;
  bit hold_prev = 0;

  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      hold_prev = 0;
    end else begin
      if (hold_prev && out_valid) chk("hold_stable", oFmap, held);
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_output: got oFmap %0h, required no output", oFmap);
        end else begin
          e = sb.pop_front();
          chk("ofmap_relu", oFmap, e.f1);
          chk("ovf_relu", ovf, e.ov1);
          chk("valid_norelu", out_valid_n, 1);
          chk("ofmap_norelu", oFmap_n, e.f0);
          chk("ovf_norelu", ovf_n, e.ov0);
        end
      end
      hold_prev = out_valid && !out_ready;
      held      = oFmap;
    end
  end

  initial begin
    load(0, 0, 0, 0, 0, 0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_ofmap", oFmap, 0);
    chk("rst_part", {31'd0, part}, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_in_ready", in_ready, 1);

    // Basic
    load(1, 2, 3, 1, 1, -1);
    send_vector();
    tick(); tick();

    // Backpressure
    rdy_mode = 2;
    send_vector();
    for (int i = 0; i < 5; i++) begin
      chk("bp_in_ready", in_ready, 0);
      chk("bp_out_valid", out_valid, 1);
      tick();
    end
    rdy_mode = 0;
    tick();
    chk("bp_release_valid", out_valid, 0);
    chk("bp_release_ready", in_ready, 1);

    // Clear mid-vector
    junk_then_clear();
    load(1, 2, 3, 1, 1, -1);
    send_vector();
    tick(); tick();

    // Saturation, sticky ovf, RELU=0 negative saturation
    load(7, 7, 7, 7, 7, 7);
    send_vector();
    load(0, 0, 0, 0, 7, 7);
    send_vector();
    load(7, 7, 7, 7, -7, -7);
    send_vector();
    tick(); tick();

    // Async reset while output pending
    rdy_mode = 2;
    load(1, 2, 3, 1, 1, -1);
    send_vector();
    tick();
    rst = 1'b1;
    #1;
    chk("arst_out_valid", out_valid, 0);
    chk("arst_ofmap", oFmap, 0);
    chk("arst_part", {31'd0, part}, 0);
    chk("arst_ovf", ovf, 0);
    chk("arst_ovf_norelu", ovf_n, 0);
    sb.delete();
    ovf_m1 = 0;
    ovf_m0 = 0;
    #1 rst = 1'b0;
    rdy_mode = 0;
    tick();
    chk("arst_in_ready", in_ready, 1);

    // Randomised vectors with random backpressure and occasional flushes
    rdy_mode = 1;
    for (int v = 0; v < 40; v++) begin
      for (int i = 0; i < 4; i++) begin
        xv[i]    = int'($urandom_range(0, 15)) - 8;
        wm[0][i] = int'($urandom_range(0, 15)) - 8;
        wm[1][i] = int'($urandom_range(0, 15)) - 8;
      end
      if ($urandom_range(0, 4) == 0) junk_then_clear();
      send_vector();
    end

    rdy_mode = 0;
    for (int n = 0; n < 100 && sb.size() > 0; n++) tick();
    if (sb.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: %0d outputs outstanding, required 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/hub_linear_fold_seq.md
Name: hub_linear_fold_seq

Overview:
Self-sequencing folded fully-connected layer for the uBrain FC stack. It takes the IDIM-wide input vector as FOLD slices of SDIM elements over a valid/ready stream and accumulates ODIM partial dot products across the slices. It then applies shift, optional ReLU and saturation, and presents the result on a valid/ready output. The block drives the fold index used to address the external weight buffer, so no external part/load/sel/clear sequencing is needed.

Parameters:
IDIM, 128, total input vector length.
SDIM, 32, elements per fold slice; IDIM must be a multiple of SDIM.
FOLD, IDIM/SDIM, number of slices per vector.
ODIM, 16, output channels.
IWID, 8, signed two's-complement width of fmap and weight elements.
AWID, 2*IWID+$clog2(IDIM), accumulator width.
OWID, IWID, signed output width.
SHFT, IWID-1, arithmetic right shift applied to the accumulator before clamping.
RELU, 1, 1 clamps negative results to 0.
PWID, ($clog2(FOLD)<1)?1:$clog2(FOLD), fold index width.

Ports:
clk  in  1  clock, rising edge.
rst  in  1  asynchronous reset, active-high.
clear  in  1  synchronous flush of the current vector.
in_valid  in  1  slice valid.
in_ready  out  1  block accepts a slice.
iFmap  in  SDIM x IWID  current slice, element s maps to input index part*SDIM+s.
iWeig  in  ODIM*SDIM x IWID  weights for current slice, index o*SDIM+s.
part  out  PWID  fold index of the next slice expected; addresses the weight buffer.
out_valid  out  1  result vector valid.
out_ready  in  1  downstream accepts the result.
oFmap  out  ODIM x OWID  result vector.
ovf  out  1  sticky saturation flag.

Behaviour:
- Reset: state=ACC, part=0, acc=0, out_valid=0, oFmap all 0, ovf=0. in_ready=1 in the first cycle after reset deassertion.
- psum[o] = signed sum over s of iFmap[s]*iWeig[o*SDIM+s]. This is combinational from the slice inputs, sign-extended to AWID.
- State ACC: in_ready=1. A handshake (in_valid&in_ready) loads acc[o]=psum[o] when part==0 and adds acc[o]+=psum[o] otherwise, wrapping at AWID bits.
  - If part<FOLD-1, part increments.
  - If part==FOLD-1, part returns to 0 and the state moves to OUT. In that same handshake cycle, the final sum is also processed: r=(acc_final>>>SHFT); r<0 and RELU=1 gives 0; r above max(OWID) gives max; r below min(OWID) gives min, reached only when RELU=0. The clamped value is registered into oFmap and out_valid is set to 1.
  - Any clamp to max or min sets ovf. A ReLU zeroing does not set ovf.
- State OUT: in_ready=0. oFmap and out_valid hold until out_ready=1. On out_valid&out_ready, out_valid clears and the state returns to ACC.
- Latency: output valid in the cycle after the FOLD-th slice handshake. Throughput is one vector per FOLD+1 cycles when out_ready stays high.
- FOLD==1: every accepted slice goes directly to OUT.
- clear: highest priority. In any state, part=0, acc=0, out_valid=0, state=ACC, and any slice presented that cycle is dropped. oFmap is not zeroed. ovf is cleared only by rst.
- out_ready asserted while out_valid=0: ignored.
- Async rst mid-vector: immediate return to reset values. The partial vector is lost.

Optional Feature:
HUB_BIAS_EN. When defined, an input port iBias [ODIM] x AWID is added and acc[o] is initialised to iBias[o]+psum[o] on the part==0 handshake. iBias is sampled only in that cycle. When undefined, there is no port and the initial value is psum[o].

Test Plan:
All scenarios use IDIM=4, SDIM=2, FOLD=2, ODIM=2, IWID=4, OWID=4, SHFT=0, RELU=1.
- Basic: x=[1,2,3,1]; out0 weights all 1; out1 weights all -1. Slices sent back-to-back with out_ready=1 -> part sequence 0,1,0. One cycle after the second handshake: oFmap=[7,0], out_valid=1, ovf=0.
- Saturation: x all 7, weights all 7 (sum 196) -> oFmap=[7,7], ovf=1. ovf stays 1 across the next vector [0,0,0,0], whose result is oFmap=[0,0].
- Backpressure: out_ready=0 for 5 cycles after out_valid -> in_ready=0 and oFmap stable for those cycles. Asserting out_ready gives out_valid low and in_ready high the next cycle.
- Clear mid-vector: accept slice 0 (x=[7,7]), assert clear, then send the full vector from the Basic scenario -> result [7,0], with no contribution from the flushed slice.
- Reset mid-OUT: assert rst while out_valid=1 -> out_valid=0, oFmap=0, part=0, ovf=0 immediately, without waiting for a clock edge.
- RELU=0 variant: Basic vector -> oFmap=[7,-7]. All weights -7 with x all 7 -> oFmap=[-8,-8], ovf=1.
